// File: rtl/rinse_mode.sv
// rinse_mode: rinse-stage sequencer of the washer controller.
// Runs 1-3 rounds of fill / agitate / drain, paced by a TICK_DIV prescaler,
// and flags completion to the dewater stage via rinse_end_sign.
`timescale 1ns/1ps

module rinse_mode #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic       start,
  input  logic       rinse_start,
  input  logic [2:0] weight,
  input  logic [1:0] rinse_times,
  output logic       rinse_end_sign,
  output logic       water_in_light,
  output logic       rinsing_light,
  output logic       water_out_light,
  output logic [2:0] water_level,
  output logic [7:0] rinse_count,
  output logic [1:0] rinse_index
);

  // Prescaler sizing; TICK_DIV >= 2 keeps the width at least one bit.
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Light vector bit order: {water_in, rinsing, water_out}.
  localparam logic [2:0] LIGHT_IN   = 3'b100;
  localparam logic [2:0] LIGHT_RNS  = 3'b010;
  localparam logic [2:0] LIGHT_OUT  = 3'b001;
  localparam logic [2:0] LIGHT_NONE = 3'b000;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WATER_IN  = 3'd1;
  localparam logic [2:0] S_RINSING   = 3'd2;
  localparam logic [2:0] S_WATER_OUT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    level_q, level_d;
  logic [2:0]    timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    t_q, t_d;
  logic [1:0]    r_q, r_d;
  logic [2:0]    lights_q, lights_d;
  logic          end_q, end_d;

  logic       active;
  logic       run;
  logic       in_phase;
  logic       tick;
  logic [2:0] weight_clamped;
  logic [1:0] times_clamped;

  // Run qualification and prescaler terminal count.
  assign active   = power & rinse_start;
  assign run      = active & start;
  assign in_phase = (state_q == S_WATER_IN) || (state_q == S_RINSING) ||
                    (state_q == S_WATER_OUT);
  assign tick     = run & in_phase & (presc_q == PRESC_LAST);

  // Load parameters are sanitised before latching: level 1..5, rounds 1..3.
  assign weight_clamped = (weight == 3'd0) ? 3'd1 :
                          (weight > 3'd5)  ? 3'd5 : weight;
  assign times_clamped  = (rinse_times == 2'd0) ? 2'd1 : rinse_times;

  // Next-state and datapath update; pause leaves every register as is.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    timer_d  = timer_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    t_d      = t_q;
    r_d      = r_q;
    lights_d = lights_q;

    if (!active) begin
      // Losing power or enable abandons the stage immediately; no drain.
      state_d  = S_IDLE;
      level_d  = 3'd0;
      timer_d  = 3'd0;
      presc_d  = '0;
      idx_d    = 2'd0;
      lights_d = LIGHT_NONE;
    end else if (run) begin
      if (in_phase) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end

      case (state_q)
        S_IDLE: begin
          state_d  = S_WATER_IN;
          t_d      = weight_clamped;
          r_d      = times_clamped;
          idx_d    = 2'd0;
          level_d  = 3'd0;
          timer_d  = 3'd0;
          presc_d  = '0;
          lights_d = LIGHT_IN;
        end

        S_WATER_IN: begin
          if (tick) begin
            level_d = level_q + 3'd1;
            if ((level_q + 3'd1) == t_q) begin
              state_d  = S_RINSING;
              timer_d  = t_q;
              presc_d  = '0;
              lights_d = LIGHT_RNS;
            end else begin
              lights_d[2] = ~lights_q[2];
            end
          end
        end

        S_RINSING: begin
          if (tick) begin
            timer_d = timer_q - 3'd1;
            if (timer_q == 3'd1) begin
              state_d  = S_WATER_OUT;
              presc_d  = '0;
              lights_d = LIGHT_OUT;
            end else begin
              lights_d[1] = ~lights_q[1];
            end
          end
        end

        S_WATER_OUT: begin
          if (tick) begin
            level_d = level_q - 3'd1;
            if (level_q == 3'd1) begin
              presc_d = '0;
              if (idx_q < (r_q - 2'd1)) begin
                // Next round starts straight away with an empty drum.
                state_d  = S_WATER_IN;
                idx_d    = idx_q + 2'd1;
                lights_d = LIGHT_IN;
              end else begin
                state_d  = S_DONE;
                lights_d = LIGHT_NONE;
              end
            end else begin
              lights_d[0] = ~lights_q[0];
            end
          end
        end

        S_DONE: begin
          lights_d = LIGHT_NONE;
          level_d  = 3'd0;
        end

        default: begin
          state_d  = S_IDLE;
          level_d  = 3'd0;
          timer_d  = 3'd0;
          presc_d  = '0;
          idx_d    = 2'd0;
          lights_d = LIGHT_NONE;
        end
      endcase
    end

    end_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      level_q  <= 3'd0;
      timer_q  <= 3'd0;
      presc_q  <= '0;
      idx_q    <= 2'd0;
      t_q      <= 3'd0;
      r_q      <= 2'd0;
      lights_q <= LIGHT_NONE;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      t_q      <= t_d;
      r_q      <= r_d;
      lights_q <= lights_d;
      end_q    <= end_d;
    end
  end

  assign rinse_end_sign  = end_q;
  assign water_in_light  = lights_q[2];
  assign rinsing_light   = lights_q[1];
  assign water_out_light = lights_q[0];
  assign water_level     = level_q;
  assign rinse_index     = idx_q;

  logic [7:0] t8;
  logic [7:0] rem8;
  logic [7:0] later_rounds;

  // Remaining stage time: current phase residue plus untouched later phases/rounds.
  always_comb begin
    t8           = 8'(t_q);
    rem8         = 8'(r_q) - 8'd1 - 8'(idx_q);
    later_rounds = 8'd3 * t8 * rem8;
    rinse_count  = 8'd0;
    case (state_q)
      S_WATER_IN:  rinse_count = (t8 - 8'(level_q)) + (8'd2 * t8) + later_rounds;
      S_RINSING:   rinse_count = 8'(timer_q) + t8 + later_rounds;
      S_WATER_OUT: rinse_count = 8'(level_q) + later_rounds;
      default:     rinse_count = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_rinse_mode.sv
// Self-checking bench for rinse_mode: table of load/round settings run to
// completion against a closed-form timeline, plus pause, power-drop and
// reset-in-DONE sequences.
`timescale 1ns/1ps

module tb_rinse_mode;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       power;
  logic       start;
  logic       rinse_start;
  logic [2:0] weight;
  logic [1:0] rinse_times;
  logic       rinse_end_sign;
  logic       water_in_light;
  logic       rinsing_light;
  logic       water_out_light;
  logic [2:0] water_level;
  logic [7:0] rinse_count;
  logic [1:0] rinse_index;

  always #5 clk = ~clk;

  rinse_mode #(.TICK_DIV(TD)) dut (
    .clk             (clk),
    .rst             (rst),
    .power           (power),
    .start           (start),
    .rinse_start     (rinse_start),
    .weight          (weight),
    .rinse_times     (rinse_times),
    .rinse_end_sign  (rinse_end_sign),
    .water_in_light  (water_in_light),
    .rinsing_light   (rinsing_light),
    .water_out_light (water_out_light),
    .water_level     (water_level),
    .rinse_count     (rinse_count),
    .rinse_index     (rinse_index)
  );

  typedef struct {
    logic       end_s;
    logic       wi;
    logic       ri;
    logic       wo;
    logic [2:0] lvl;
    logic [7:0] cnt;
    logic [1:0] idx;
  } exp_t;

  typedef struct {
    logic [2:0] w;
    logic [1:0] rt;
    int         t;
    int         r;
    int         cnt0;
    int         done_at;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Expected outputs n run-edges after the start edge (n=0 is the start edge).
  function automatic exp_t model(input bit idle, input int t, input int r, input int n);
    exp_t e;
    int   k;
    int   kp;
    e.end_s = 1'b0; e.wi = 1'b0; e.ri = 1'b0; e.wo = 1'b0;
    e.lvl = 3'd0; e.cnt = 8'd0; e.idx = 2'd0;
    if (idle) return e;
    k = n / TD;
    if (k >= 3 * t * r) begin
      e.end_s = 1'b1;
      e.idx   = 2'(r - 1);
      return e;
    end
    kp    = k % (3 * t);
    e.idx = 2'(k / (3 * t));
    e.cnt = 8'(3 * t * r - k);
    if (kp < t) begin
      e.lvl = 3'(kp);
      e.wi  = ((kp % 2) == 0);
    end else if (kp < 2 * t) begin
      e.lvl = 3'(t);
      e.ri  = (((kp - t) % 2) == 0);
    end else begin
      e.lvl = 3'(3 * t - kp);
      e.wo  = (((kp - 2 * t) % 2) == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Push expectation, advance one edge, then pop and compare away from the edge.
  task automatic step(input exp_t e, input string tag);
    exp_t x;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk({tag, ".end"},   int'(rinse_end_sign),  int'(x.end_s));
    chk({tag, ".wi"},    int'(water_in_light),  int'(x.wi));
    chk({tag, ".ri"},    int'(rinsing_light),   int'(x.ri));
    chk({tag, ".wo"},    int'(water_out_light), int'(x.wo));
    chk({tag, ".level"}, int'(water_level),     int'(x.lvl));
    chk({tag, ".count"}, int'(rinse_count),     int'(x.cnt));
    chk({tag, ".index"}, int'(rinse_index),     int'(x.idx));
  endtask

  task automatic set_in(input logic p, input logic s, input logic rs,
                        input logic [2:0] w, input logic [1:0] rt);
    power       = p;
    start       = s;
    rinse_start = rs;
    weight      = w;
    rinse_times = rt;
  endtask

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_seen;
    int   ec;
    exp_t idle_e;

    vecs[0] = '{3'd2, 2'd1, 2, 1,  6,  24};
    vecs[1] = '{3'd5, 2'd3, 5, 3, 45, 180};
    vecs[2] = '{3'd0, 2'd0, 1, 1,  3,  12};
    vecs[3] = '{3'd7, 2'd2, 5, 2, 30, 120};
    vecs[4] = '{3'd3, 2'd2, 3, 2, 18,  72};

    idle_e = model(1'b1, 1, 1, 0);

    // Reset with run requested must still hold IDLE.
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 3'd3, 2'd2);
    step(idle_e, "reset0");
    step(idle_e, "reset1");
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    rst = 1'b0;
    step(idle_e, "idle");

    // Table: full runs with per-edge timeline checks.
    for (int v = 0; v < 5; v++) begin
      set_in(1'b1, 1'b1, 1'b1, vecs[v].w, vecs[v].rt);
      done_seen = -1;
      for (int n = 0; n <= vecs[v].done_at + 2; n++) begin
        step(model(1'b0, vecs[v].t, vecs[v].r, n), $sformatf("vec%0d.n%0d", v, n));
        if (n == 0) chk($sformatf("vec%0d.count_e0", v), int'(rinse_count), vecs[v].cnt0);
        if (rinse_end_sign && done_seen < 0) done_seen = n;
        // Inputs changing after latching must be ignored.
        if (n == 1) begin
          weight      = 3'd6;
          rinse_times = 2'd3;
        end
      end
      chk($sformatf("vec%0d.done_edge", v), done_seen, vecs[v].done_at);
      rinse_start = 1'b0;
      step(idle_e, $sformatf("vec%0d.drop", v));
    end

    // Pause for 10 edges in RINSING: outputs frozen, DONE delayed by 10.
    set_in(1'b1, 1'b1, 1'b1, 3'd2, 2'd1);
    done_seen = -1;
    ec = 0;
    for (int n = 0; n <= 9; n++) begin
      step(model(1'b0, 2, 1, n), $sformatf("pause.n%0d", n));
      ec++;
    end
    start = 1'b0;
    for (int p = 0; p < 10; p++) begin
      step(model(1'b0, 2, 1, 9), $sformatf("pause.hold%0d", p));
      ec++;
    end
    start = 1'b1;
    for (int n = 10; n <= 26; n++) begin
      step(model(1'b0, 2, 1, n), $sformatf("pause.n%0d", n));
      if (rinse_end_sign && done_seen < 0) done_seen = ec;
      ec++;
    end
    chk("pause.done_edge", done_seen, 34);
    rinse_start = 1'b0;
    step(idle_e, "pause.drop");

    // Power drop mid-fill at level 3, then clean restart.
    set_in(1'b1, 1'b1, 1'b1, 3'd5, 2'd1);
    for (int n = 0; n <= 12; n++) begin
      step(model(1'b0, 5, 1, n), $sformatf("pwr.n%0d", n));
    end
    chk("pwr.level_before_drop", int'(water_level), 3);
    power = 1'b0;
    step(idle_e, "pwr.off");
    power = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      step(model(1'b0, 5, 1, n), $sformatf("pwr.restart_n%0d", n));
    end
    rinse_start = 1'b0;
    step(idle_e, "pwr.drop");

    // Reset while in DONE with start held.
    set_in(1'b1, 1'b1, 1'b1, 3'd1, 2'd1);
    for (int n = 0; n <= 13; n++) begin
      step(model(1'b0, 1, 1, n), $sformatf("rstdone.n%0d", n));
    end
    chk("rstdone.in_done", int'(rinse_end_sign), 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(idle_e, $sformatf("rstdone.hold%0d", i));
    end
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
